// File: rtl/mips_muldiv.sv
// Iterative HI/LO unit: radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Define MIPS_MULDIV_DIV_EN to build the divider; without it DIV/DIVU finish in two cycles as no-ops.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} stateT;

  stateT              stateQ, stateD;
  logic [CntW-1:0]    cntQ, cntD;
  logic [2*WIDTH-1:0] accQ, accD;  // {upper, lower}: product, or {remainder, quotient}
  logic [WIDTH-1:0]   opndQ, opndD;
  logic               isDivQ, isDivD;
  logic               negResQ, negResD;
  logic [WIDTH-1:0]   hiQ, hiD, loQ, loD;
  logic               busyQ, busyD, doneQ, doneD;

  logic               signedOp;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext, prodFix;

  // The most-negative value negates to itself, which is already its unsigned magnitude.
  assign signedOp = ~op[0];
  assign aMag     = (signedOp && a[WIDTH-1]) ? -a : a;
  assign bMag     = (signedOp && b[WIDTH-1]) ? -b : b;

  assign mulSum  = {1'b0, accQ[2*WIDTH-1:WIDTH]} + {1'b0, opndQ};
  assign mulNext = accQ[0] ? {mulSum, accQ[WIDTH-1:1]} : {1'b0, accQ[2*WIDTH-1:1]};
  assign prodFix = negResQ ? -accQ : accQ;

`ifdef MIPS_MULDIV_DIV_EN
  logic               negRemQ, negRemD;
  logic [WIDTH:0]     divShift;
  logic [WIDTH-1:0]   divDiff, quot, rem;
  logic               divGe;
  logic [2*WIDTH-1:0] divNext;

  assign divShift = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, opndQ};
  assign divDiff  = divShift[WIDTH-1:0] - opndQ;
  assign divNext  = divGe ? {divDiff, accQ[WIDTH-2:0], 1'b1}
                          : {divShift[WIDTH-1:0], accQ[WIDTH-2:0], 1'b0};
  // A zero divisor leaves the dividend magnitude as remainder, so only LO needs forcing.
  assign quot = (opndQ == '0) ? '1 : (negResQ ? -accQ[WIDTH-1:0] : accQ[WIDTH-1:0]);
  assign rem  = negRemQ ? -accQ[2*WIDTH-1:WIDTH] : accQ[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    accD    = accQ;
    opndD   = opndQ;
    isDivD  = isDivQ;
    negResD = negResQ;
`ifdef MIPS_MULDIV_DIV_EN
    negRemD = negRemQ;
`endif
    hiD     = hiQ;
    loD     = loQ;
    busyD   = busyQ;
    doneD   = 1'b0;
    case (stateQ)
      StIdle: begin
        if (start && !flush) begin
          isDivD  = op[1];
          negResD = signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
          opndD   = bMag;
          accD    = {{WIDTH{1'b0}}, aMag};
          cntD    = '0;
          busyD   = 1'b1;
`ifdef MIPS_MULDIV_DIV_EN
          negRemD = signedOp && a[WIDTH-1];
          stateD  = StCalc;
`else
          stateD  = op[1] ? StFix : StCalc;
`endif
        end else begin
          if (hi_we) hiD = wdata;
          if (lo_we) loD = wdata;
        end
      end
      StCalc: begin
        if (flush) begin
          stateD = StIdle;
          busyD  = 1'b0;
        end else begin
`ifdef MIPS_MULDIV_DIV_EN
          accD = isDivQ ? divNext : mulNext;
`else
          accD = mulNext;
`endif
          cntD = cntQ + CntW'(1);
          if (cntQ == LastIter) stateD = StFix;
        end
      end
      StFix: begin
        if (!flush) begin
`ifdef MIPS_MULDIV_DIV_EN
          if (isDivQ) begin
            hiD = rem;
            loD = quot;
          end else begin
            hiD = prodFix[2*WIDTH-1:WIDTH];
            loD = prodFix[WIDTH-1:0];
          end
`else
          if (!isDivQ) begin
            hiD = prodFix[2*WIDTH-1:WIDTH];
            loD = prodFix[WIDTH-1:0];
          end
`endif
          doneD = 1'b1;
        end
        stateD = StIdle;
        busyD  = 1'b0;
      end
      default: begin
        stateD = StIdle;
        busyD  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      accQ    <= '0;
      opndQ   <= '0;
      isDivQ  <= 1'b0;
      negResQ <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      negRemQ <= 1'b0;
`endif
      hiQ     <= '0;
      loQ     <= '0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      accQ    <= accD;
      opndQ   <= opndD;
      isDivQ  <= isDivD;
      negResQ <= negResD;
`ifdef MIPS_MULDIV_DIV_EN
      negRemQ <= negRemD;
`endif
      hiQ     <= hiD;
      loQ     <= loD;
      busyQ   <= busyD;
      doneQ   <= doneD;
    end
  end

  assign busy = busyQ;
  assign done = doneQ;
  assign hi   = hiQ;
  assign lo   = loQ;
endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO width; legal range 8 to 64, even values only.
REQ-002 clk  input  1  core clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  WIDTH  rs operand (multiplicand or dividend).
REQ-007 b  input  WIDTH  rt operand (multiplier or divisor).
REQ-008 flush  input  1  abort any in-flight operation (exception or branch squash).
REQ-009 hi_we, lo_we  input  1 each  MTHI/MTLO write strobes.
REQ-010 wdata  input  WIDTH  MTHI/MTLO data.
REQ-011 busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO/MULT/DIV while this is high.
REQ-012 done  output  1  one-cycle pulse marking the first cycle in which new HI/LO values are visible.
REQ-013 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 States: IDLE, CALC, FIX; busy SHALL be 1 exactly in CALC and FIX.
REQ-015 IDLE to CALC: start=1 and flush=0 in cycle N; a, b and op are latched at that edge and the iteration counter is cleared.
REQ-016 CALC: one iteration per cycle for exactly WIDTH cycles (N+1 to N+WIDTH), then go to FIX.
REQ-017 Multiply: radix-2 shift-add on operand magnitudes, producing a 2*WIDTH-bit product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-018 Divide: restoring division on magnitudes; LO = quotient, HI = remainder.
REQ-019 Signed ops (MULT, DIV): the product is negated if the operand signs differ; the quotient is negated if the signs differ; the remainder takes the dividend's sign.
REQ-020 The most-negative operand is handled by WIDTH+1-bit magnitude arithmetic, with no overflow trap; DIV of -2^(WIDTH-1) by -1 gives LO = -2^(WIDTH-1), HI = 0.
REQ-021 Divide by zero: HI = a, LO = all ones, for both DIV and DIVU; latency is unchanged.
REQ-022 FIX (cycle N+WIDTH+1): sign fix-up is applied; at the closing edge HI/LO are written, done is set, and the state returns to IDLE.
REQ-023 done SHALL be 1 in cycle N+WIDTH+2 only; a new start is accepted in that same cycle.
REQ-024 start while busy SHALL be ignored; it is not queued.
REQ-025 flush in CALC or FIX: return to IDLE at the next edge; HI/LO are unchanged and done stays 0.
REQ-026 flush together with start in IDLE: start is ignored.
REQ-027 hi_we/lo_we in IDLE with start=0: HI/LO take wdata at the edge.
REQ-028 hi_we/lo_we while busy, or in the same cycle as an accepted start, are ignored.
REQ-029 done is registered; all outputs are driven directly from flops.

Reset
REQ-030 rst low, asynchronously: state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, internal counter and accumulators = 0.
REQ-031 Reset asserted mid-operation discards the operation with no done pulse.
REQ-032 The first start is accepted in the first cycle after the first rising edge with rst high.

Configuration
REQ-033 Macro MIPS_MULDIV_DIV_EN defined: the divider datapath is compiled in and behaves per REQ-018 to REQ-021.
REQ-034 Macro MIPS_MULDIV_DIV_EN undefined: no divider logic is present.
REQ-035 Without the macro, a DIV/DIVU start still sets busy for cycle N+1 only, then pulses done in cycle N+2 with HI/LO unchanged; MULT/MULTU are unaffected.

Verification
REQ-036 WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start in cycle N -> busy cycles N+1 to N+33; done in N+34; HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 MULT a=-3, b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 DIVU a=0x1234, b=0 -> HI=0x00001234, LO=0xFFFFFFFF, done in N+34.
REQ-039 Start MULT, assert flush in cycle N+10 -> IDLE in N+11, no done pulse, HI/LO keep prior values; a start in N+11 is accepted.
REQ-040 hi_we with wdata=0xA5A5A5A5 while busy -> HI unchanged; the same write in IDLE -> HI=0xA5A5A5A5 in the next cycle.
REQ-041 Drop rst in cycle N+5 of a DIV -> hi=lo=0, busy=0, no done; repeat all scenarios with WIDTH=16 and with MIPS_MULDIV_DIV_EN undefined, checking the done cycle per REQ-035.
